// File: rtl/hazard_sequencer_if.sv
// Pipeline-side bundle for hazard_sequencer: ID/EX/MEM observation inputs,
// hold/flush/bubble controls, halt handshake and performance counters.
interface hazard_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic             id_is_bcond;
  logic             br_taken;
  logic             ex_regwrite;
  logic             ex_memtoreg;
  logic             ex_flagwrite;
  logic [4:0]       ex_rd;
  logic             mem_regwrite;
  logic [4:0]       mem_rd;
  logic             halt_req;

  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             br_enable;
  logic             halt_ack;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_bcond,
           br_taken, ex_regwrite, ex_memtoreg, ex_flagwrite, ex_rd,
           mem_regwrite, mem_rd, halt_req,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, br_enable,
           halt_ack, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_is_bcond,
           br_taken, ex_regwrite, ex_memtoreg, ex_flagwrite, ex_rd,
           mem_regwrite, mem_rd, halt_req,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, br_enable,
           halt_ack, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard/run-control sequencer for the 5-stage CPU: stalls, branch flush and halt/drain.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  typedef logic [DW-1:0]    dcnt_t;
  typedef logic [CNT_W-1:0] cnt_t;

  state_t r_state;
  state_t w_state_nxt;
  dcnt_t  r_dcnt;
  dcnt_t  w_dcnt_nxt;
  logic   r_halt_ack;

  logic w_raw_ex;
  logic w_raw_mem;
  logic w_flag_haz;
  logic w_stall;
  logic w_pc_hold;
  logic w_ifid_hold;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_br_enable;

  // X31 reads as zero, so a write to it can never feed a consumer.
  assign w_raw_ex   = bus.ex_regwrite && (bus.ex_rd != 5'd31) &&
                      ((bus.id_uses_rn && (bus.id_rn == bus.ex_rd)) ||
                       (bus.id_uses_rm && (bus.id_rm == bus.ex_rd)));
  assign w_raw_mem  = bus.mem_regwrite && (bus.mem_rd != 5'd31) &&
                      ((bus.id_uses_rn && (bus.id_rn == bus.mem_rd)) ||
                       (bus.id_uses_rm && (bus.id_rm == bus.mem_rd)));
  assign w_flag_haz = bus.id_is_bcond && bus.ex_flagwrite;
  assign w_stall    = bus.id_valid && (w_raw_ex || w_raw_mem || w_flag_haz);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_RUN;
      r_dcnt     <= '0;
      r_halt_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_halt_ack <= (r_state == S_HALTED);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_pc_hold     = 1'b0;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_br_enable   = 1'b1;

    unique case (r_state)
      S_RUN: begin
        w_ifid_flush = bus.br_taken;
        if (bus.halt_req && !w_stall && !bus.br_taken) begin
          w_state_nxt = S_DRAIN;
          w_dcnt_nxt  = dcnt_t'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: begin
        // A taken branch still loads its target so the held PC is the resume point.
        w_pc_hold    = !bus.br_taken;
        w_ifid_flush = 1'b1;
        if (!bus.halt_req) begin
          w_state_nxt = S_RUN;
        end else if (!w_stall) begin
          if (r_dcnt == dcnt_t'(1)) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_dcnt_nxt = r_dcnt - dcnt_t'(1);
          end
        end
      end
      S_HALTED: begin
        w_pc_hold    = 1'b1;
        w_ifid_flush = 1'b1;
        if (!bus.halt_req) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase

    // Stall overrides every state's controls, including the drain flush.
    if (w_stall) begin
      w_pc_hold     = 1'b1;
      w_ifid_hold   = 1'b1;
      w_idex_bubble = 1'b1;
      w_br_enable   = 1'b0;
      w_ifid_flush  = 1'b0;
    end

    if (!reset) begin
      w_pc_hold     = 1'b0;
      w_ifid_hold   = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_br_enable   = 1'b1;
    end
  end

  assign bus.pc_hold     = w_pc_hold;
  assign bus.ifid_hold   = w_ifid_hold;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.br_enable   = w_br_enable;
  assign bus.halt_ack    = r_halt_ack && reset;

`ifdef HAZARD_PERF_CNT_EN
  cnt_t r_stall_cnt;
  cnt_t r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + cnt_t'(1);
      end
      if (w_ifid_flush && (r_state == S_RUN) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + cnt_t'(1);
      end
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  localparam cnt_t CNT_ZERO = '0;

  assign bus.stall_cnt = CNT_ZERO;
  assign bus.flush_cnt = CNT_ZERO;
`endif

endmodule
